pipelined_nbits_adder: RTL



---
 rtl/pipelined_nbits_adder_if.sv | 22 ++
 rtl/pipelined_nbits_adder.sv | 78 +++++++
 2 files changed

// File: rtl/pipelined_nbits_adder_if.sv
// pipelined_nbits_adder_if: valid/ready operand stream in, result stream out
interface pipelined_nbits_adder_if #(parameter int WIDTH = 32);
  logic in_valid;
  logic in_ready;
  logic op;
  logic carry_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic carry_out;
  logic overflow;
  modport master (
    output in_valid, op, carry_in, a, b, out_ready,
    input in_ready, out_valid, sum, carry_out, overflow
  );
  modport slave (
    input in_valid, op, carry_in, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/pipelined_nbits_adder.sv
// pipelined_nbits_adder: WIDTH-bit add/sub with the carry chain split into STAGES registered segments
module pipelined_nbits_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst,
  pipelined_nbits_adder_if.slave bus
);
  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad_params
    $fatal(1, "pipelined_nbits_adder: WIDTH must be a positive multiple of STAGES");
  end
  localparam int SEG = WIDTH / STAGES;
  logic [STAGES-1:0] v_q, c_q, v_x, c_x, c_n;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_x [STAGES];
  logic [WIDTH-1:0] b_x [STAGES];
  logic [WIDTH-1:0] s_x [STAGES];
  logic [WIDTH-1:0] s_n [STAGES];
  logic [SEG:0] seg;
  logic ov_q, ov_n, adv;
  assign adv = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum = s_q[STAGES-1];
  assign bus.carry_out = c_q[STAGES-1];
  assign bus.overflow = ov_q;
  // stage k consumes its inputs (port for k=0, previous register otherwise) and adds its own segment
  always_comb begin
    seg = '0;
    v_x[0] = bus.in_valid;
    a_x[0] = bus.a;
    b_x[0] = bus.op ? ~bus.b : bus.b;
    c_x[0] = bus.carry_in;
    s_x[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_x[k] = v_q[k-1];
      a_x[k] = a_q[k-1];
      b_x[k] = b_q[k-1];
      c_x[k] = c_q[k-1];
      s_x[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg = {1'b0, a_x[k][k*SEG +: SEG]} + {1'b0, b_x[k][k*SEG +: SEG]} + (SEG+1)'(c_x[k]);
      s_n[k] = s_x[k];
      s_n[k][k*SEG +: SEG] = seg[SEG-1:0];
      c_n[k] = seg[SEG];
    end
    ov_n = (a_x[STAGES-1][WIDTH-1] == b_x[STAGES-1][WIDTH-1]) &&
           (s_n[STAGES-1][WIDTH-1] != a_x[STAGES-1][WIDTH-1]);
  end
  // whole pipeline shifts together on advance; data only loads with a valid beat so idle X never enters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      ov_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_x;
      for (int k = 0; k < STAGES; k++) begin
        if (v_x[k]) begin
          a_q[k] <= a_x[k];
          b_q[k] <= b_x[k];
          s_q[k] <= s_n[k];
          c_q[k] <= c_n[k];
        end
      end
      if (v_x[STAGES-1]) ov_q <= ov_n;
    end
  end
endmodule
